key_edge_detect: RTL and testbench



---
 rtl/key_edge_detect.sv | 137 +++++++++++++
 tb/tb_key_edge_detect.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_edge_detect.sv
// Key pin front end: synchroniser, power-up mask, edge pulses with lockout.
// Ports: CLK/RSTn; Pin_In raw pin; H2L_Sig/L2H_Sig pulses; Key_Level; Bounce_Cnt.
module key_edge_detect #(
  parameter logic [15:0] T_STARTUP = 16'd4_999,
  parameter logic [19:0] T_LOCK    = 20'd499_999
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Pin_In,
  output logic       H2L_Sig,
  output logic       L2H_Sig,
  output logic       Key_Level,
  output logic [7:0] Bounce_Cnt
);

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_LOCK
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  logic [19:0] r_cnt;
  logic [19:0] w_cnt_nxt;
  logic        r_h2l;
  logic        w_h2l_nxt;
  logic        r_l2h;
  logic        w_l2h_nxt;
  logic        r_level;
  logic        w_level_nxt;
  logic [7:0]  r_bcnt;
  logic [7:0]  w_bcnt_nxt;

  logic        w_fall;
  logic        w_rise;
  logic        w_st_done;
  logic        w_lk_done;

  assign w_fall    = r_prev & ~r_sync2;
  assign w_rise    = ~r_prev & r_sync2;
  assign w_st_done = (r_cnt == {4'd0, T_STARTUP});
  assign w_lk_done = (r_cnt == T_LOCK);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= Pin_In;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_STARTUP;
      r_cnt   <= 20'd0;
      r_h2l   <= 1'b0;
      r_l2h   <= 1'b0;
      r_level <= 1'b1;
      r_bcnt  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_h2l   <= w_h2l_nxt;
      r_l2h   <= w_l2h_nxt;
      r_level <= w_level_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_h2l_nxt   = 1'b0;
    w_l2h_nxt   = 1'b0;
    w_level_nxt = r_level;
    w_bcnt_nxt  = r_bcnt;
    unique case (r_state)
      ST_STARTUP: begin
        if (w_st_done) begin
          w_level_nxt = r_sync2;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 20'd0;
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      ST_IDLE: begin
        w_cnt_nxt = 20'd0;
        if (w_fall && r_level) begin
          w_h2l_nxt   = 1'b1;
          w_level_nxt = 1'b0;
          w_state_nxt = ST_LOCK;
        end else if (w_rise && !r_level) begin
          w_l2h_nxt   = 1'b1;
          w_level_nxt = 1'b1;
          w_state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if ((w_fall || w_rise) && (r_bcnt != 8'hFF))
          w_bcnt_nxt = r_bcnt + 8'd1;
        if (w_lk_done) begin
          w_cnt_nxt = 20'd0;
          // Level moved under the lockout: report it now and lock again.
          if (r_sync2 != r_level) begin
            w_h2l_nxt   = ~r_sync2;
            w_l2h_nxt   = r_sync2;
            w_level_nxt = r_sync2;
            w_state_nxt = ST_LOCK;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      default: begin
        w_state_nxt = ST_STARTUP;
        w_cnt_nxt   = 20'd0;
      end
    endcase
  end

  assign H2L_Sig    = r_h2l;
  assign L2H_Sig    = r_l2h;
  assign Key_Level  = r_level;
  assign Bounce_Cnt = r_bcnt;

endmodule

// File: tb/tb_key_edge_detect.sv
// Randomised bench for key_edge_detect against a timestamp-based model.
// Ports driven: CLK, RSTn, Pin_In; all outputs checked every cycle.
module tb_key_edge_detect;

  localparam int TST = 9;
  localparam int TLK = 99;

  logic       CLK;
  logic       RSTn;
  logic       Pin_In;
  logic       H2L_Sig;
  logic       L2H_Sig;
  logic       Key_Level;
  logic [7:0] Bounce_Cnt;

  key_edge_detect #(
    .T_STARTUP(16'd9),
    .T_LOCK   (20'd99)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Pin_In    (Pin_In),
    .H2L_Sig   (H2L_Sig),
    .L2H_Sig   (L2H_Sig),
    .Key_Level (Key_Level),
    .Bounce_Cnt(Bounce_Cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: pin value sampled at each clock edge since reset release,
  // lockout expressed as the absolute edge number where it ends.
  logic pins [0:19999];
  int   e;
  int   lock_end;
  logic m_lvl;
  logic m_h2l;
  logic m_l2h;
  int   m_bc;
  int   n_h2l;
  int   n_l2h;
  int   at_h2l;
  int   at_l2h;

  function automatic logic pin(input int i);
    return (i < 1) ? 1'b1 : pins[i];
  endfunction

  task automatic model_reset();
    e = 0;
    lock_end = 0;
    m_lvl = 1'b1;
    m_h2l = 1'b0;
    m_l2h = 1'b0;
    m_bc = 0;
  endtask

  task automatic emit(input logic s);
    m_lvl = s;
    if (s) m_l2h = 1'b1;
    else   m_h2l = 1'b1;
    lock_end = e + TLK + 1;
  endtask

  task automatic model_step();
    logic s;
    logic ed;
    s  = pin(e - 2);
    ed = (s != pin(e - 3));
    m_h2l = 1'b0;
    m_l2h = 1'b0;
    if (e <= TST + 1) begin
      if (e == TST + 1) m_lvl = s;
    end else if (lock_end != 0) begin
      if (ed && m_bc < 255) m_bc++;
      if (e == lock_end) begin
        if (s != m_lvl) emit(s);
        else lock_end = 0;
      end
    end else if (ed && s != m_lvl) begin
      emit(s);
    end
  endtask

  task automatic tick(input logic v);
    @(negedge CLK);
    Pin_In = v;
    @(posedge CLK);
    e++;
    pins[e] = v;
    model_step();
    #1;
    chk("h2l", H2L_Sig, m_h2l);
    chk("l2h", L2H_Sig, m_l2h);
    chk("lvl", Key_Level, m_lvl);
    chk("bcnt", Bounce_Cnt, m_bc);
    chk("excl", H2L_Sig & L2H_Sig, 0);
    if (H2L_Sig) begin n_h2l++; at_h2l = e; end
    if (L2H_Sig) begin n_l2h++; at_l2h = e; end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_h2l"}, H2L_Sig, 0);
    chk({tag, "_l2h"}, L2H_Sig, 0);
    chk({tag, "_lvl"}, Key_Level, 1);
    chk({tag, "_bc"}, Bounce_Cnt, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    int l0;
    int len;
    logic v;
    n_h2l = 0;
    n_l2h = 0;
    at_h2l = 0;
    at_l2h = 0;
    RSTn = 1'b0;
    Pin_In = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_vals("rst");
    @(posedge CLK);
    #2 RSTn = 1'b1;

    for (int i = 0; i < 12; i++) tick(1'b0);
    chk("st_lvl", Key_Level, 0);
    chk("st_none", n_h2l + n_l2h, 0);

    for (int i = 0; i < 120; i++) tick(1'b1);

    tick(1'b0);
    tick(1'b0);
    chk("lat1", H2L_Sig, 0);
    tick(1'b0);
    chk("lat2", H2L_Sig, 1);
    tick(1'b0);
    chk("lat3", H2L_Sig, 0);
    chk("lat_lvl", Key_Level, 0);
    for (int i = 0; i < 110; i++) tick(1'b0);
    for (int i = 0; i < 110; i++) tick(1'b1);

    h0 = n_h2l;
    l0 = n_l2h;
    tick(1'b0);
    for (int k = 0; k < 5; k++) begin
      repeat (3) tick(1'b1);
      repeat (3) tick(1'b0);
    end
    for (int i = 0; i < 80; i++) tick(1'b0);
    chk("bnc_cnt", Bounce_Cnt, 10);
    chk("bnc_h2l", n_h2l - h0, 1);
    chk("bnc_l2h", n_l2h - l0, 0);

    for (int i = 0; i < 110; i++) tick(1'b1);
    h0 = n_h2l;
    l0 = n_l2h;
    for (int i = 0; i < 30; i++) tick(1'b0);
    for (int i = 0; i < 210; i++) tick(1'b1);
    chk("rel_gap", at_l2h - at_h2l, 100);
    chk("rel_h2l", n_h2l - h0, 1);
    chk("rel_l2h", n_l2h - l0, 1);
    chk("rel_lvl", Key_Level, 1);
    chk("rel_bc", Bounce_Cnt, 11);

    for (int i = 0; i < 300; i++) begin
      v = (i % 2) != 0;
      tick(v);
    end
    chk("sat1", Bounce_Cnt, 255);
    for (int i = 0; i < 20; i++) tick(1'b1);
    chk("sat2", Bounce_Cnt, 255);
    for (int i = 0; i < 250; i++) tick(1'b1);

    for (int i = 0; i < 20; i++) tick(1'b0);
    @(posedge CLK);
    #3 RSTn = 1'b0;
    #1;
    chk_reset_vals("arst");
    model_reset();
    repeat (2) @(posedge CLK);
    #2 RSTn = 1'b1;

    h0 = n_h2l;
    l0 = n_l2h;
    for (int i = 0; i < 10; i++) begin
      v = 1'($urandom_range(0, 1));
      tick(v);
    end
    chk("mask2", (n_h2l - h0) + (n_l2h - l0), 0);

    v = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) len = $urandom_range(100, 250);
      else len = $urandom_range(1, 8);
      v = ~v;
      for (int j = 0; j < len; j++) tick(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
